life_seq_ctrl: RTL and testbench

- Sequencer for the 8x8 Game of Life DATAPATH.
- Turns raw user keys into the datapath's `state`, `btn0`, `btn1` and `stop` controls.
- Paces generations at a programmable rate and detects end of game: extinct, still-life or generation limit.
- Sits between the board I/O and DATAPATH; watches the 64-bit `grid` it returns.

---
 rtl/life_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_life_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_seq_ctrl.sv
// rtl/life_seq_ctrl.sv - key/step sequencer and end-of-game detector for the 8x8 Life datapath
// Optional single-step in PAUSE: define LIFE_SEQ_SINGLE_STEP_EN.
module life_seq_ctrl #(
  parameter int STEP_DIV     = 4,
  parameter int GEN_MAX      = 1000,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        key_set,
  input  logic        key_kill,
  input  logic        key_go,
  input  logic        key_clear,
  input  logic [63:0] grid,
  output logic [1:0]  state,
  output logic        btn0,
  output logic        btn1,
  output logic        stop,
  output logic [5:0]  cursor,
  output logic [15:0] gen_count,
  output logic        running
);

  typedef enum logic [2:0] {S_CLEAR, S_EDIT, S_RUN, S_PAUSE, S_DONE} fsm_t;

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);
  localparam logic [15:0] GEN_LIM  = 16'(GEN_MAX);
  localparam logic [15:0] CLR_INIT = 16'(CLEAR_CYCLES);

  fsm_t        fsm_q, fsm_d;
  logic [15:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] div_q, div_d;
  logic        step_q, step_d;
  logic        chk_q, chk_d;
  logic        pause_pend_q, pause_pend_d;
  logic [63:0] last_grid_q, last_grid_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic [1:0]  state_q, state_d;
  logic        btn0_q, btn0_d;
  logic        btn1_q, btn1_d;
  logic        stop_q, stop_d;
  logic [5:0]  cursor_q, cursor_d;
  logic [15:0] gen_q, gen_d;
  logic        running_q, running_d;

  logic [3:0]  key_raw;
  logic [3:0]  key_edge;
  logic        set_e, kill_e, go_e, clr_e;
  logic        end_hit;

  // Edge detection on raw keys; a single register stage per key
  always_comb begin
    key_raw    = {key_clear, key_go, key_kill, key_set};
    key_prev_d = key_raw;
    key_edge   = key_raw & ~key_prev_q;
    set_e      = key_edge[0];
    kill_e     = key_edge[1];
    go_e       = key_edge[2];
    clr_e      = key_edge[3];
    end_hit    = (grid == 64'd0) || (grid == last_grid_q) ||
                 ((GEN_LIM != 16'd0) && (gen_q == GEN_LIM));
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clka) begin
    if (rst) begin
      fsm_q        <= S_CLEAR;
      clr_cnt_q    <= CLR_INIT;
      div_q        <= 16'd0;
      step_q       <= 1'b0;
      chk_q        <= 1'b0;
      pause_pend_q <= 1'b0;
      last_grid_q  <= 64'd0;
      key_prev_q   <= 4'd0;
      state_q      <= 2'b00;
      btn0_q       <= 1'b0;
      btn1_q       <= 1'b0;
      stop_q       <= 1'b0;
      cursor_q     <= 6'd0;
      gen_q        <= 16'd0;
      running_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      clr_cnt_q    <= clr_cnt_d;
      div_q        <= div_d;
      step_q       <= step_d;
      chk_q        <= chk_d;
      pause_pend_q <= pause_pend_d;
      last_grid_q  <= last_grid_d;
      key_prev_q   <= key_prev_d;
      state_q      <= state_d;
      btn0_q       <= btn0_d;
      btn1_q       <= btn1_d;
      stop_q       <= stop_d;
      cursor_q     <= cursor_d;
      gen_q        <= gen_d;
      running_q    <= running_d;
    end
  end

  // Next FSM state; a go press landing on a step defers PAUSE until its check is done
  always_comb begin
    fsm_d        = fsm_q;
    pause_pend_d = pause_pend_q;
    if (clr_e) begin
      fsm_d        = S_CLEAR;
      pause_pend_d = 1'b0;
    end else begin
      case (fsm_q)
        S_CLEAR: if (clr_cnt_q <= 16'd1) fsm_d = S_EDIT;
        S_EDIT:  if (go_e) fsm_d = S_RUN;
        S_RUN: begin
          if (chk_q) begin
            pause_pend_d = 1'b0;
            if (end_hit)                    fsm_d = S_DONE;
            else if (pause_pend_q || go_e)  fsm_d = S_PAUSE;
          end else if (step_q) begin
            if (go_e) pause_pend_d = 1'b1;
          end else if (go_e) begin
            fsm_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          pause_pend_d = 1'b0;
          if (chk_q && end_hit) fsm_d = S_DONE;
          else if (go_e)        fsm_d = S_RUN;
        end
        S_DONE:  if (go_e) fsm_d = S_EDIT;
        default: fsm_d = S_CLEAR;
      endcase
    end
  end

  // Generation pacing: divider, step strobe, post-step check strobe, clear hold count
  always_comb begin
    if ((fsm_d == S_RUN) && (fsm_q == S_RUN))
      div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
    else
      div_d = 16'd0;

    step_d = (fsm_d == S_RUN) && (fsm_q == S_RUN) && (div_d == DIV_LAST);
`ifdef LIFE_SEQ_SINGLE_STEP_EN
    if ((fsm_q == S_PAUSE) && (fsm_d == S_PAUSE) && set_e && !step_q && !chk_q)
      step_d = 1'b1;
`endif

    chk_d = step_q && (fsm_d != S_CLEAR);

    if ((fsm_d == S_CLEAR) && (fsm_q == S_CLEAR) && !clr_e)
      clr_cnt_d = clr_cnt_q - 16'd1;
    else
      clr_cnt_d = CLR_INIT;
  end

  // Registered outputs derived from the upcoming state; cursor advances after each write pulse
  always_comb begin
    case (fsm_d)
      S_CLEAR: state_d = 2'b00;
      S_EDIT:  state_d = 2'b01;
      default: state_d = step_d ? 2'b10 : 2'b11;
    endcase

    btn0_d    = (fsm_q == S_EDIT) && (fsm_d == S_EDIT) && set_e;
    btn1_d    = (fsm_q == S_EDIT) && (fsm_d == S_EDIT) && kill_e && !set_e;
    stop_d    = (fsm_d == S_DONE);
    running_d = (fsm_d == S_RUN);

    if (fsm_d == S_CLEAR) cursor_d = 6'd0;
    else                  cursor_d = cursor_q + {5'd0, (btn0_q | btn1_q)};

    if (fsm_d == S_CLEAR)                          gen_d = 16'd0;
    else if ((fsm_q == S_DONE) && (fsm_d == S_EDIT)) gen_d = 16'd0;
    else if (step_q && (gen_q != 16'hFFFF))        gen_d = gen_q + 16'd1;
    else                                           gen_d = gen_q;

    if (fsm_d == S_CLEAR) last_grid_d = 64'd0;
    else if (step_q)      last_grid_d = grid;
    else                  last_grid_d = last_grid_q;
  end

  assign state     = state_q;
  assign btn0      = btn0_q;
  assign btn1      = btn1_q;
  assign stop      = stop_q;
  assign cursor    = cursor_q;
  assign gen_count = gen_q;
  assign running   = running_q;

endmodule

// File: tb/tb_life_seq_ctrl.sv
// tb/tb_life_seq_ctrl.sv - directed bench for life_seq_ctrl (default and GEN_MAX=3 instances)
module tb_life_seq_ctrl;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0E00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0004_0404_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0400_0000;

  logic        clka = 1'b0;
  logic        rst, key_set, key_kill, key_go, key_clear;
  logic [63:0] grid_a, grid_b;
  logic [1:0]  state_a, state_b;
  logic        btn0_a, btn1_a, stop_a, running_a;
  logic        btn0_b, btn1_b, stop_b, running_b;
  logic [5:0]  cursor_a, cursor_b;
  logic [15:0] gen_a, gen_b;
  int          mode;
  int          steps_a, steps_b;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_b0 = 0;
  int          n_b1 = 0;
  int          b0_base, b1_base;

  always #5 clka = ~clka;

  life_seq_ctrl u_dut_a (
    .clka(clka), .rst(rst), .key_set(key_set), .key_kill(key_kill), .key_go(key_go),
    .key_clear(key_clear), .grid(grid_a), .state(state_a), .btn0(btn0_a), .btn1(btn1_a),
    .stop(stop_a), .cursor(cursor_a), .gen_count(gen_a), .running(running_a)
  );

  life_seq_ctrl #(.GEN_MAX(3)) u_dut_b (
    .clka(clka), .rst(rst), .key_set(key_set), .key_kill(key_kill), .key_go(key_go),
    .key_clear(key_clear), .grid(grid_b), .state(state_b), .btn0(btn0_b), .btn1(btn1_b),
    .stop(stop_b), .cursor(cursor_b), .gen_count(gen_b), .running(running_b)
  );

  // Datapath stand-in: board pattern as a function of steps taken since EDIT/CLEAR
  function automatic logic [63:0] grid_of(input int m, input int steps);
    case (m)
      0:       return (steps % 2 == 1) ? BLINK_V : BLINK_H;
      1:       return BLOCK;
      default: return (steps == 0) ? SINGLE : 64'd0;
    endcase
  endfunction

  always @(posedge clka) begin
    if (rst || state_a == 2'b00 || state_a == 2'b01) steps_a <= 0;
    else if (state_a == 2'b10)                      steps_a <= steps_a + 1;
    if (rst || state_b == 2'b00 || state_b == 2'b01) steps_b <= 0;
    else if (state_b == 2'b10)                      steps_b <= steps_b + 1;
  end

  always_comb begin
    grid_a = grid_of(mode, steps_a);
    grid_b = grid_of(mode, steps_b);
  end

  always @(negedge clka) begin
    if (btn0_a) n_b0 <= n_b0 + 1;
    if (btn1_a) n_b1 <= n_b1 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic pulse(input logic s, input logic k);
    key_set  = s;
    key_kill = k;
    tick();
    key_set  = 1'b0;
    key_kill = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; key_set = 1'b0; key_kill = 1'b0; key_go = 1'b0; key_clear = 1'b0;
    mode = 0;
    steps_a = 0; steps_b = 0;
    tick(); tick(); tick();
    check("rst_state", 64'(state_a), 64'd0);
    check("rst_cursor", 64'(cursor_a), 64'd0);
    check("rst_gen", 64'(gen_a), 64'd0);
    check("rst_stop", 64'(stop_a), 64'd0);
    check("rst_running", 64'(running_a), 64'd0);
    check("rst_btn", 64'({btn0_a, btn1_a}), 64'd0);
    rst = 1'b0;
    tick();
    check("clr_hold1", 64'(state_a), 64'd0);
    tick();
    check("clr_to_edit", 64'(state_a), 64'd1);

    // EDIT: 12 writes, 6 alive and 6 dead
    b0_base = n_b0; b1_base = n_b1;
    for (int i = 0; i < 4; i++) begin
      key_set = 1'b1; tick();
      check("set_pulse", 64'({btn0_a, btn1_a}), 64'b10);
      key_set = 1'b0; tick();
      key_kill = 1'b1; tick();
      check("kill_pulse", 64'({btn0_a, btn1_a}), 64'b01);
      key_kill = 1'b0; tick();
    end
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    check("btn0_count", 64'(n_b0 - b0_base), 64'd6);
    check("btn1_count", 64'(n_b1 - b1_base), 64'd6);
    check("cursor_12", 64'(cursor_a), 64'd12);
    for (int i = 0; i < 64; i++) pulse(i[0], ~i[0]);
    check("cursor_wrap", 64'(cursor_a), 64'd12);
    key_set = 1'b1; key_kill = 1'b1; tick();
    check("both_btn0", 64'(btn0_a), 64'd1);
    check("both_btn1", 64'(btn1_a), 64'd0);
    key_set = 1'b0; key_kill = 1'b0; tick();
    check("both_cursor", 64'(cursor_a), 64'd13);

    // RUN with blinker; go beats set in the same cycle
    mode = 0;
    key_go = 1'b1; key_set = 1'b1; tick();
    check("go_run", 64'(running_a), 64'd1);
    check("go_no_write", 64'(btn0_a), 64'd0);
    check("go_state", 64'(state_a), 64'd3);
    key_go = 1'b0; key_set = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("run_state", 64'(state_a), (k % 4 == 3) ? 64'd2 : 64'd3);
      check("run_gen", 64'(gen_a), 64'(k / 4));
      check("run_stop", 64'(stop_a), 64'd0);
    end
    key_go = 1'b1; tick();
    check("pause_running", 64'(running_a), 64'd0);
    check("pause_state", 64'(state_a), 64'd3);
    check("pause_stop", 64'(stop_a), 64'd0);
    key_go = 1'b0; tick();
`ifdef LIFE_SEQ_SINGLE_STEP_EN
    key_set = 1'b1; tick();
    check("ss_step", 64'(state_a), 64'd2);
    key_set = 1'b0; tick();
    check("ss_after", 64'(state_a), 64'd3);
    check("ss_gen", 64'(gen_a), 64'd4);
    tick();
    check("ss_stop", 64'(stop_a), 64'd0);
    check("ss_once", 64'(state_a), 64'd3);
`else
    key_set = 1'b1; tick();
    check("pause_set_ign", 64'(state_a), 64'd3);
    check("pause_no_btn", 64'(btn0_a), 64'd0);
    key_set = 1'b0; tick();
    check("pause_gen", 64'(gen_a), 64'd3);
`endif

    // Reset in PAUSE
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    check("rstp_state0", 64'(state_a), 64'd0);
    check("rstp_gen", 64'(gen_a), 64'd0);
    check("rstp_cursor", 64'(cursor_a), 64'd0);
    tick();
    check("rstp_edit", 64'(state_a), 64'd1);

    // Still-life block
    mode = 1;
    key_go = 1'b1; tick(); key_go = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        check("blk_stop_pre", 64'(stop_a), 64'd0);
        check("blk_gen_pre", 64'(gen_a), 64'd1);
      end
    end
    check("blk_stop", 64'(stop_a), 64'd1);
    check("blk_gen", 64'(gen_a), 64'd1);
    check("blk_running", 64'(running_a), 64'd0);
    key_go = 1'b1; tick();
    check("done_edit", 64'(state_a), 64'd1);
    check("done_stop", 64'(stop_a), 64'd0);
    check("done_gen", 64'(gen_a), 64'd0);
    key_go = 1'b0; tick();

    // Extinction
    mode = 2;
    key_go = 1'b1; tick(); key_go = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check("die_stop", 64'(stop_a), 64'd1);
    check("die_gen", 64'(gen_a), 64'd1);

    // Align both instances, then GEN_MAX=3 limit on u_dut_b
    key_clear = 1'b1; tick();
    key_clear = 1'b0; tick(); tick();
    check("clr_edit_b", 64'(state_b), 64'd1);
    mode = 0;
    pulse(1'b1, 1'b0);
    key_go = 1'b1; tick(); key_go = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 9)  check("gm_stop_mid", 64'(stop_b), 64'd0);
      if (k == 12) check("gm_gen3", 64'(gen_b), 64'd3);
    end
    check("gm_stop", 64'(stop_b), 64'd1);
    check("gm_gen", 64'(gen_b), 64'd3);
    check("gm_a_stop", 64'(stop_a), 64'd0);
    key_go = 1'b1; tick();
    check("gm_edit", 64'(state_b), 64'd1);
    check("gm_stop_clr", 64'(stop_b), 64'd0);
    check("gm_gen_clr", 64'(gen_b), 64'd0);
    check("gm_cursor", 64'(cursor_b), 64'd1);
    key_go = 1'b0; tick();
    key_go = 1'b1; tick();
    key_go = 1'b0; tick(); tick();
    check("mid_run", 64'(running_a), 64'd1);

    // key_clear mid-RUN
    key_clear = 1'b1; tick();
    check("kc_state0", 64'(state_a), 64'd0);
    check("kc_gen", 64'(gen_a), 64'd0);
    check("kc_cursor", 64'(cursor_a), 64'd0);
    check("kc_running", 64'(running_a), 64'd0);
    key_clear = 1'b0; tick();
    check("kc_state1", 64'(state_a), 64'd0);
    tick();
    check("kc_edit", 64'(state_a), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
